// File: rtl/sel_cnt_gen.sv
// Select-count sequencer for the threshold mux: start/stop FSM, up/down wrap or saturate.
// Optional overlap monitor enabled by defining SEL_OVERLAP_FLAG_EN.
module sel_cnt_gen #(
    parameter int unsigned           WIDTH  = 3,
    parameter logic [WIDTH-1:0]      THRESH = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic             wrap,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             ge_thr,
    output logic             le_thr,
    output logic             busy,
    output logic             done,
    output logic             overlap,
    output logic [7:0]       overlap_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_step;
    logic             at_bound;

    assign cnt_step = dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
    assign at_bound = dir ? (cnt_q == CNT_MAX) : (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = load_val;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // stop wins over a same-cycle step so the count is frozen where it was
                if (stop) begin
                    state_d = S_IDLE;
                end else if (en) begin
                    if (wrap)          cnt_d   = cnt_step;
                    else if (at_bound) state_d = S_DONE;
                    else               cnt_d   = cnt_step;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt    = cnt_q;
    assign ge_thr = (cnt_q >= THRESH);
    assign le_thr = (cnt_q <= THRESH);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

`ifdef SEL_OVERLAP_FLAG_EN
    logic [7:0] ovl_cnt_q, ovl_cnt_d;
    logic       ovl_w;

    assign ovl_w = ge_thr & le_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovl_cnt_q <= '0;
        else        ovl_cnt_q <= ovl_cnt_d;
    end

    always_comb begin
        ovl_cnt_d = ovl_cnt_q;
        if (state_q == S_IDLE && start)
            ovl_cnt_d = '0;
        else if (state_q == S_RUN && ovl_w && ovl_cnt_q != 8'hFF)
            ovl_cnt_d = ovl_cnt_q + 8'd1;
    end

    assign overlap     = ovl_w;
    assign overlap_cnt = ovl_cnt_q;
`else
    assign overlap     = 1'b0;
    assign overlap_cnt = 8'd0;
`endif

endmodule
